sp_controller: RTL

- Sequences all stack-pointer traffic for the 16-bit core: PUSH, POP, CALL and RET requests from the decode stage.
- Owns the SP register and drives a byte-wide, synchronous-read stack memory port.
- The stack grows downward. One word is 2 bytes: high byte at SP+1, low byte at SP.
- Checks overflow and underflow against fixed bounds before any memory access and reports faults to the trap logic.

---
 rtl/sp_ctrl_pkg.sv | 39 +++
 rtl/sp_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ctrl_pkg
//  Description : Shared constants for the stack-pointer controller.
//                - op_code values (PUSH/POP/CALL/RET)
//                - fault codes reported alongside done
//                - controller state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package sp_ctrl_pkg;

    // Request op codes from the decode stage
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    // Fault codes reported with done
    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UNF  = 2'b10;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_HI   = 3'd1,
        ST_WR_LO   = 3'd2,
        ST_RD_LO   = 3'd3,
        ST_RD_HI   = 3'd4,
        ST_RD_WAIT = 3'd5
    } sp_state_e;

    // PUSH and CALL both store a word; POP and RET both load one.
    function automatic logic is_store_op(input logic [1:0] code);
        return (code == OP_PUSH) || (code == OP_CALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sp_controller
//  Description : Stack-pointer controller for the 16-bit core. Sequences
//                PUSH/POP/CALL/RET onto a byte-wide synchronous-read stack
//                memory, owns SP and reports overflow/underflow faults.
//                The stack grows downward; a word is stored high byte at
//                SP+1, low byte at SP.
//  Ports       : clk, rst (async, active high)
//                op_valid/op_code/op_data/op_ready  - request handshake
//                done/fault/fault_code              - completion status
//                result_data/result_is_ret          - popped word, RET flag
//                sp                                 - current stack pointer
//                mem_addr/mem_wdata/mem_we/mem_re   - stack memory port
//                mem_rdata                          - read byte (1-cycle lat.)
//  Revision    : 1.0  initial release
// ============================================================================
module sp_controller
    import sp_ctrl_pkg::*;
#(
    parameter int             W           = 16,
    parameter logic [W-1:0]   STACK_BASE  = 16'h0100,
    parameter logic [W-1:0]   STACK_LIMIT = 16'h00F8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [1:0]    op_code,
    input  logic [W-1:0]  op_data,
    output logic          op_ready,
    output logic          done,
    output logic          fault,
    output logic [1:0]    fault_code,
    output logic [W-1:0]  result_data,
    output logic          result_is_ret,
    output logic [W-1:0]  sp,
    output logic [W-1:0]  mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata
);

    localparam logic [W-1:0] c_ONE   = W'(1);
    localparam logic [W-1:0] c_TWO   = W'(2);
    localparam logic [W:0]   c_TWO_X = (W+1)'(2);

    // Bounds are compared one bit wider than SP so no arithmetic can wrap.
    localparam logic [W:0]   c_OVF_BOUND = {1'b0, STACK_LIMIT} + c_TWO_X;
    localparam logic [W:0]   c_BASE_X    = {1'b0, STACK_BASE};

    sp_state_e      r_state;
    logic [W-1:0]   r_sp;
    logic [W-1:0]   r_data;          // word latched at acceptance
    logic           r_is_ret;        // latched op was RET
    logic [7:0]     r_lo;            // low byte captured during a pop
    logic           r_done;
    logic           r_fault;
    logic [1:0]     r_fault_code;
    logic [W-1:0]   r_result;
    logic           r_result_is_ret;

    logic           w_ovf;
    logic           w_unf;

    assign w_ovf = ({1'b0, r_sp} < c_OVF_BOUND);
    assign w_unf = (({1'b0, r_sp} + c_TWO_X) > c_BASE_X);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_sp            <= STACK_BASE;
            r_data          <= '0;
            r_is_ret        <= 1'b0;
            r_lo            <= 8'h00;
            r_done          <= 1'b0;
            r_fault         <= 1'b0;
            r_fault_code    <= FLT_NONE;
            r_result        <= '0;
            r_result_is_ret <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_data   <= op_data;
                        r_is_ret <= (op_code == OP_RET);
                        if (is_store_op(op_code)) begin
                            if (w_ovf) begin
                                // Rejected: report next cycle, stay idle
                                r_done          <= 1'b1;
                                r_fault         <= 1'b1;
                                r_fault_code    <= FLT_OVF;
                                r_result_is_ret <= 1'b0;
                            end else begin
                                r_state <= ST_WR_HI;
                            end
                        end else begin
                            if (w_unf) begin
                                r_done          <= 1'b1;
                                r_fault         <= 1'b1;
                                r_fault_code    <= FLT_UNF;
                                r_result_is_ret <= 1'b0;
                            end else begin
                                r_state <= ST_RD_LO;
                            end
                        end
                    end
                end
                ST_WR_HI: begin
                    r_state <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    r_sp            <= r_sp - c_TWO;
                    r_state         <= ST_IDLE;
                    r_done          <= 1'b1;
                    r_fault         <= 1'b0;
                    r_fault_code    <= FLT_NONE;
                    r_result_is_ret <= 1'b0;
                end
                ST_RD_LO: begin
                    r_state <= ST_RD_HI;
                end
                ST_RD_HI: begin
                    // Data for the RD_LO read arrives this cycle
                    r_lo    <= mem_rdata;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_result        <= {mem_rdata, r_lo};
                    r_sp            <= r_sp + c_TWO;
                    r_state         <= ST_IDLE;
                    r_done          <= 1'b1;
                    r_fault         <= 1'b0;
                    r_fault_code    <= FLT_NONE;
                    r_result_is_ret <= r_is_ret;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory port: decoded from state so reset removes strobes at once
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (r_state)
            ST_WR_HI: begin
                mem_addr  = r_sp - c_ONE;
                mem_wdata = r_data[W-1:W-8];
                mem_we    = 1'b1;
            end
            ST_WR_LO: begin
                mem_addr  = r_sp - c_TWO;
                mem_wdata = r_data[7:0];
                mem_we    = 1'b1;
            end
            ST_RD_LO: begin
                mem_addr = r_sp;
                mem_re   = 1'b1;
            end
            ST_RD_HI: begin
                mem_addr = r_sp + c_ONE;
                mem_re   = 1'b1;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = 8'h00;
                mem_we    = 1'b0;
                mem_re    = 1'b0;
            end
        endcase
    end

    assign op_ready      = (r_state == ST_IDLE);
    assign done          = r_done;
    assign fault         = r_fault;
    assign fault_code    = r_fault_code;
    assign result_data   = r_result;
    assign result_is_ret = r_result_is_ret;
    assign sp            = r_sp;

endmodule
`default_nettype wire
